// File: rtl/idli_urx_word_m.sv
// UART receive front-end for the execute stage.
// Receives 8N1 frames, packs two bytes (low byte first) into a 16-bit word and
// holds it in a one-entry buffer that EX reads as four nibbles over one sync period.
// Assembly and buffering run independently, so one word can be in flight while
// another waits in the buffer.
module idli_urx_word_m #(
    parameter int unsigned CLKS_PER_BIT = 16
) (
    input  logic       i_urx_gck,
    input  logic       i_urx_rst_n,
    input  logic       i_urx_rx,
    input  logic [1:0] i_urx_ctr,
    input  logic       i_urx_acp,
    output logic       o_urx_vld,
    output logic [3:0] o_urx_data,
    output logic [3:0] o_urx_bits,
    output logic       o_urx_ferr,
    output logic       o_urx_ovr
);

    localparam int unsigned CW = $clog2(CLKS_PER_BIT);
    // Last count value before a sample point: half a bit for the start bit, a full bit otherwise.
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL_LAST = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StStop,
        StBreak
    } state_t;

    state_t         state_q, state_d;
    logic           sync_q;
    logic           rx_s;
    logic [CW-1:0]  clk_q, clk_d;
    logic [3:0]     bits_q, bits_d;
    logic [15:0]    asm_q, asm_d;
    logic [15:0]    buf_q, buf_d;
    logic           vld_q, vld_d;
    logic           ferr_q, ferr_d;
    logic           ovr_q, ovr_d;
    logic           word_done;
    logic           clr;

    // Two-flop synchronizer for the asynchronous RX pin; both stages reset to idle-high.
    always_ff @(posedge i_urx_gck or negedge i_urx_rst_n) begin
        if (!i_urx_rst_n) begin
            sync_q <= 1'b1;
            rx_s   <= 1'b1;
        end else begin
            sync_q <= i_urx_rx;
            rx_s   <= sync_q;
        end
    end

    // Receiver and buffer state registers.
    always_ff @(posedge i_urx_gck or negedge i_urx_rst_n) begin
        if (!i_urx_rst_n) begin
            state_q <= StIdle;
            clk_q   <= '0;
            bits_q  <= '0;
            asm_q   <= '0;
            buf_q   <= '0;
            vld_q   <= 1'b0;
            ferr_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            clk_q   <= clk_d;
            bits_q  <= bits_d;
            asm_q   <= asm_d;
            buf_q   <= buf_d;
            vld_q   <= vld_d;
            ferr_q  <= ferr_d;
            ovr_q   <= ovr_d;
        end
    end

    // Frame FSM: bit timing, data sampling into the assembly register, stop-bit checking.
    always_comb begin
        state_d   = state_q;
        clk_d     = clk_q;
        bits_d    = bits_q;
        asm_d     = asm_q;
        ferr_d    = 1'b0;
        word_done = 1'b0;
        unique case (state_q)
            StIdle: begin
                clk_d = '0;
                if (!rx_s) begin
                    state_d = StStart;
                end
            end
            StStart: begin
                if (clk_q == HALF_LAST) begin
                    clk_d = '0;
                    // A start bit that is high again at mid-bit was a glitch.
                    state_d = rx_s ? StIdle : StData;
                end else begin
                    clk_d = clk_q + 1'b1;
                end
            end
            StData: begin
                if (clk_q == FULL_LAST) begin
                    clk_d         = '0;
                    asm_d[bits_q] = rx_s;
                    bits_d        = bits_q + 4'd1;
                    if (bits_q[2:0] == 3'd7) begin
                        state_d = StStop;
                    end
                end else begin
                    clk_d = clk_q + 1'b1;
                end
            end
            StStop: begin
                if (clk_q == FULL_LAST) begin
                    clk_d = '0;
                    if (rx_s) begin
                        state_d   = StIdle;
                        // bits_q has wrapped to 0 only after the second byte.
                        word_done = (bits_q == 4'd0);
                    end else begin
                        ferr_d  = 1'b1;
                        bits_d  = '0;
                        state_d = StBreak;
                    end
                end else begin
                    clk_d = clk_q + 1'b1;
                end
            end
            StBreak: begin
                clk_d = '0;
                if (rx_s) begin
                    state_d = StIdle;
                end
            end
            default: begin
                clk_d   = '0;
                state_d = StIdle;
            end
        endcase
    end

    // Output buffer: load on completion, clear on EX accept, flag overrun when full.
    always_comb begin
        clr   = (i_urx_ctr == 2'd3) && i_urx_acp && vld_q;
        buf_d = buf_q;
        vld_d = vld_q;
        ovr_d = 1'b0;
        if (word_done) begin
            // A clear in the same cycle frees the slot for the new word.
            if (!vld_q || clr) begin
                buf_d = asm_q;
                vld_d = 1'b1;
            end else begin
                ovr_d = 1'b1;
            end
        end else if (clr) begin
            vld_d = 1'b0;
        end
    end

    assign o_urx_vld  = vld_q;
    assign o_urx_data = buf_q[{i_urx_ctr, 2'b00} +: 4];
    assign o_urx_bits = bits_q;
    assign o_urx_ferr = ferr_q;
    assign o_urx_ovr  = ovr_q;

endmodule

// File: tb/tb_idli_urx_word_m.sv
// Directed bench for idli_urx_word_m with CLKS_PER_BIT = 16.
// Inputs change on the falling clock edge and outputs are read there too, away
// from the active edge. Frame-relative tick k is the k-th falling edge after the
// start bit is driven; the stop sample of a frame lands on the rising edge after
// tick 154, so its effects are first visible at tick 155.
module tb_idli_urx_word_m;

    logic       clk;
    logic       rst_n;
    logic       rx;
    logic [1:0] ctr;
    logic       acp;
    logic       vld;
    logic [3:0] data;
    logic [3:0] bits;
    logic       ferr;
    logic       ovr;

    int compared;
    int mismatched;
    int ferr_cnt;
    int ovr_cnt;

    logic [15:0] word;

    idli_urx_word_m #(
        .CLKS_PER_BIT(16)
    ) dut (
        .i_urx_gck  (clk),
        .i_urx_rst_n(rst_n),
        .i_urx_rx   (rx),
        .i_urx_ctr  (ctr),
        .i_urx_acp  (acp),
        .o_urx_vld  (vld),
        .o_urx_data (data),
        .o_urx_bits (bits),
        .o_urx_ferr (ferr),
        .o_urx_ovr  (ovr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count single-cycle pulses.
    always @(negedge clk) begin
        if (ferr) ferr_cnt++;
        if (ovr)  ovr_cnt++;
    end

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Start bit plus eight data bits; leaves the caller at frame tick 144.
    task automatic send_nostop(input logic [7:0] b);
        rx = 1'b0;
        tick(16);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            tick(16);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        send_nostop(b);
        rx = 1'b1;
        tick(16);
    endtask

    // Whole first byte, then the second byte up to tick 154 of its frame.
    task automatic send_word_to_stop(input logic [15:0] w);
        send_byte(w[7:0]);
        send_nostop(w[15:8]);
        rx = 1'b1;
        tick(10);
    endtask

    task automatic send_word(input logic [15:0] w);
        send_word_to_stop(w);
        tick(6);
    endtask

    task automatic read_word(output logic [15:0] w);
        for (int c = 0; c < 4; c++) begin
            ctr = 2'(c);
            #1;
            w[4*c +: 4] = data;
        end
        ctr = 2'd0;
    endtask

    task automatic consume();
        @(negedge clk);
        ctr = 2'd3;
        acp = 1'b1;
        @(negedge clk);
        acp = 1'b0;
        ctr = 2'd0;
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        ferr_cnt   = 0;
        ovr_cnt    = 0;
        rst_n      = 1'b0;
        rx         = 1'b1;
        ctr        = 2'd0;
        acp        = 1'b0;
        tick(3);
        chk("reset_vld", 16'(vld), 16'h0);
        chk("reset_data", 16'(data), 16'h0);
        chk("reset_bits", 16'(bits), 16'h0);
        chk("reset_ferr", 16'(ferr), 16'h0);
        chk("reset_ovr", 16'(ovr), 16'h0);
        rst_n = 1'b1;
        tick(10);

        // Word receipt: 0x34 then 0x12 back to back.
        send_byte(8'h34);
        chk("rx1_bits_after_byte0", 16'(bits), 16'h8);
        send_nostop(8'h12);
        chk("rx1_bits_after_byte1", 16'(bits), 16'h0);
        rx = 1'b1;
        tick(10);
        chk("rx1_vld_before", 16'(vld), 16'h0);
        tick(1);
        chk("rx1_vld_after", 16'(vld), 16'h1);
        tick(5);
        for (int c = 0; c < 4; c++) begin
            ctr = 2'(c);
            #1;
            chk($sformatf("rx1_nibble%0d", c), 16'(data), 16'(4 - c));
        end
        ctr = 2'd1;
        acp = 1'b1;
        tick(1);
        acp = 1'b0;
        ctr = 2'd0;
        chk("rx1_acp_wrong_ctr_ignored", 16'(vld), 16'h1);
        consume();
        chk("rx1_vld_cleared", 16'(vld), 16'h0);

        // Glitch: four low cycles in idle.
        tick(5);
        rx = 1'b0;
        tick(4);
        rx = 1'b1;
        tick(30);
        chk("glitch_bits", 16'(bits), 16'h0);
        chk("glitch_vld", 16'(vld), 16'h0);
        chk("glitch_ferr_cnt", 16'(ferr_cnt), 16'h0);

        // Framing error: 0xAA with stop held low for three bit-times.
        send_nostop(8'hAA);
        rx = 1'b0;
        tick(10);
        chk("ferr_before", 16'(ferr), 16'h0);
        tick(1);
        chk("ferr_pulse", 16'(ferr), 16'h1);
        chk("ferr_bits_cleared", 16'(bits), 16'h0);
        tick(1);
        chk("ferr_after", 16'(ferr), 16'h0);
        tick(36);
        rx = 1'b1;
        tick(20);
        chk("ferr_vld_none", 16'(vld), 16'h0);
        send_word(16'h6655);
        chk("ferr_cnt_once", 16'(ferr_cnt), 16'h1);
        chk("ferr_word_vld", 16'(vld), 16'h1);
        read_word(word);
        chk("ferr_word", word, 16'h6655);
        consume();
        chk("ferr_word_consumed", 16'(vld), 16'h0);

        // Overrun: second word arrives while the first is still buffered.
        tick(5);
        send_word(16'h0001);
        chk("ovr_first_vld", 16'(vld), 16'h1);
        send_word_to_stop(16'h0002);
        chk("ovr_before", 16'(ovr), 16'h0);
        tick(1);
        chk("ovr_pulse", 16'(ovr), 16'h1);
        chk("ovr_vld_held", 16'(vld), 16'h1);
        tick(1);
        chk("ovr_after", 16'(ovr), 16'h0);
        tick(4);
        read_word(word);
        chk("ovr_buf_kept", word, 16'h0001);
        chk("ovr_cnt_once", 16'(ovr_cnt), 16'h1);
        consume();
        chk("ovr_consumed", 16'(vld), 16'h0);

        // Clear and completion in the same cycle.
        tick(5);
        send_word(16'h0001);
        chk("sim_first_vld", 16'(vld), 16'h1);
        send_word_to_stop(16'hBEEF);
        ctr = 2'd3;
        acp = 1'b1;
        tick(1);
        acp = 1'b0;
        ctr = 2'd0;
        chk("sim_vld_stays", 16'(vld), 16'h1);
        chk("sim_no_ovr", 16'(ovr), 16'h0);
        read_word(word);
        chk("sim_buf_new", word, 16'hBEEF);
        tick(5);
        chk("sim_ovr_cnt", 16'(ovr_cnt), 16'h1);

        // Reset after the fifth data bit of the first byte.
        rx = 1'b0;
        tick(16);
        for (int i = 0; i < 5; i++) begin
            rx = 1'(8'hCD >> i);
            tick(16);
        end
        chk("rst_bits_before", 16'(bits), 16'h5);
        rst_n = 1'b0;
        #1;
        chk("rst_vld", 16'(vld), 16'h0);
        chk("rst_data", 16'(data), 16'h0);
        chk("rst_bits", 16'(bits), 16'h0);
        chk("rst_ferr", 16'(ferr), 16'h0);
        chk("rst_ovr", 16'(ovr), 16'h0);
        rx = 1'b1;
        tick(2);
        rst_n = 1'b1;
        tick(20);
        send_word(16'hABCD);
        chk("rst_word_vld", 16'(vld), 16'h1);
        read_word(word);
        chk("rst_word", word, 16'hABCD);
        chk("rst_ferr_cnt", 16'(ferr_cnt), 16'h1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
